// File: rtl/sdrd_deserializer_if.sv
// Bus-side signals of the SDRD deserializer: the decoded access strobes,
// the serial data bit and the valid/ready word handshake.
interface sdrd_deserializer_if #(
    parameter int WIDTH = 8
);
    logic             SSER;
    logic             BA13;
    logic             BA12;
    logic             BR_W;
    logic             SDRD;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             data_ready;

    modport master (
        output SSER, BA13, BA12, BR_W, SDRD, data_ready,
        input  data_out, data_valid
    );

    modport slave (
        input  SSER, BA13, BA12, BR_W, SDRD, data_ready,
        output data_out, data_valid
    );
endinterface

// File: rtl/sdrd_deserializer.sv
// Assembles WIDTH-bit words from the security PAL's SDRD line, taking one bit
// per decoded read access, and hands completed words out over valid/ready.
module sdrd_deserializer #(
    parameter int WIDTH      = 8,
    parameter int SAMPLE_DLY = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     resync,
    sdrd_deserializer_if.slave       bus,
    output logic                     overrun,
    output logic [$clog2(WIDTH):0]   bit_cnt
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT - 1);
    localparam logic [1:0]    WAIT_LOAD  = 2'(SAMPLE_DLY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SAMPLE,
        HOLD
    } state_t;

    state_t state;
    state_t state_nxt;

    logic             rst_meta;
    logic             rst_sync;
    logic             win_raw;
    logic             win_q;
    logic             win_d1;
    logic             win_rise;
    logic             do_sample;
    logic             word_done;
    logic             accept;
    logic [1:0]       wait_cnt;
    logic [IW-1:0]    idle_cnt;
    logic [WIDTH-2:0] shift_q;
    logic [WIDTH-1:0] shift_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta <= 1'b0;
            rst_sync <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_sync <= rst_meta;
        end
    end

    assign win_raw = ~bus.SSER & ~bus.BA13 & bus.BA12 & bus.BR_W;

    // The window stays forced closed until reset release has passed the
    // synchroniser, so no access can start in the first clocks after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q  <= 1'b0;
            win_d1 <= 1'b0;
        end else if (!rst_sync) begin
            win_q  <= 1'b0;
            win_d1 <= 1'b0;
        end else begin
            win_q  <= win_raw;
            win_d1 <= win_q;
        end
    end

    assign win_rise = win_q & ~win_d1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        do_sample = 1'b0;
        case (state)
            IDLE: begin
                if (win_rise) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (!win_q) begin
                    state_nxt = IDLE;
                end else if (wait_cnt == 2'd0) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                do_sample = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (!win_q) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (resync) begin
            state_nxt = IDLE;
            do_sample = 1'b0;
        end
    end

    assign shift_nxt = {shift_q, bus.SDRD};
    assign word_done = do_sample && (bit_cnt == LAST_BIT);
    assign accept    = !bus.data_valid || bus.data_ready;

    // Partial-word state: shift register, bit count, wait and idle counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= '0;
            bit_cnt  <= '0;
            wait_cnt <= '0;
            idle_cnt <= '0;
        end else if (resync) begin
            shift_q  <= '0;
            bit_cnt  <= '0;
            wait_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            if (state == IDLE && win_rise) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == WAIT && wait_cnt != 2'd0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end

            if (do_sample) begin
                idle_cnt <= '0;
                if (word_done) begin
                    shift_q <= '0;
                    bit_cnt <= '0;
                end else begin
                    shift_q <= shift_nxt[WIDTH-2:0];
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (win_rise) begin
                idle_cnt <= '0;
            end else if (state == IDLE && bit_cnt != '0) begin
                if (idle_cnt == IDLE_LIMIT) begin
                    shift_q  <= '0;
                    bit_cnt  <= '0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end

    // A reload on the same clock as a consume keeps valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.data_out   <= '0;
            bus.data_valid <= 1'b0;
            overrun        <= 1'b0;
        end else if (word_done && accept) begin
            bus.data_out   <= shift_nxt;
            bus.data_valid <= 1'b1;
        end else begin
            if (word_done) begin
                overrun <= 1'b1;
            end
            if (bus.data_valid && bus.data_ready) begin
                bus.data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sdrd_deserializer.sv
// Directed and randomised accesses against an access-level model of the
// deserializer: bits per access, words per WIDTH bits, valid/overrun rules.
module tb_sdrd_deserializer;

    localparam int WIDTH      = 8;
    localparam int SAMPLE_DLY = 1;
    localparam int TIMEOUT    = 255;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   resync = 1'b0;
    logic                   overrun;
    logic [$clog2(WIDTH):0] bit_cnt;

    sdrd_deserializer_if #(.WIDTH(WIDTH)) bus ();

    sdrd_deserializer #(
        .WIDTH      (WIDTH),
        .SAMPLE_DLY (SAMPLE_DLY),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .resync  (resync),
        .bus     (bus.slave),
        .overrun (overrun),
        .bit_cnt (bit_cnt)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    int         m_cnt;
    logic [7:0] m_word;
    logic [7:0] m_out;
    logic       m_valid;
    logic       m_ovr;
    logic       m_done;

    int   pulse_cycles;
    int   latency;
    logic prev_valid;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt   = 0;
        m_word  = '0;
        m_out   = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    // One accepted access appends a bit; WIDTH bits make a word, which is
    // either delivered or dropped as an overrun. A ready consumer drains it.
    task automatic model_access(input logic b, input logic rdy);
        m_done = 1'b0;
        m_word = {m_word[6:0], b};
        m_cnt++;
        if (m_cnt == WIDTH) begin
            if (!m_valid || rdy) begin
                m_out   = m_word;
                m_valid = 1'b1;
                m_done  = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
            m_cnt  = 0;
            m_word = '0;
        end
        if (rdy) m_valid = 1'b0;
    endtask

    task automatic observe(input int idx);
        if (bus.data_valid) pulse_cycles++;
        if (bus.data_valid && !prev_valid && latency < 0) latency = idx;
        prev_valid = bus.data_valid;
    endtask

    task automatic close_window();
        bus.SSER = 1'b1;
        bus.BA13 = 1'b0;
        bus.BA12 = 1'b0;
        bus.BR_W = 1'b0;
    endtask

    // kind: 0 valid read window, 1 write (BR_W=0), 2 BA13=1, 3 SSER=1
    task automatic apply_stimulus(input logic b, input int hold, input int kind, input logic rdy);
        @(negedge clk);
        bus.data_ready = rdy;
        bus.SDRD       = b;
        bus.SSER       = (kind == 3);
        bus.BA13       = (kind == 2);
        bus.BA12       = 1'b1;
        bus.BR_W       = (kind != 1);
        pulse_cycles   = 0;
        latency        = -1;
        prev_valid     = bus.data_valid;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1 observe(i);
        end
        @(negedge clk);
        close_window();
        for (int j = 0; j < 4; j++) begin
            @(posedge clk);
            #1 observe(hold + j);
        end
        if (kind == 0) model_access(b, rdy);
    endtask

    task automatic check_state(input string tag);
        check_output({tag, " bit_cnt"}, 32'(bit_cnt), 32'(m_cnt));
        check_output({tag, " data_out"}, 32'(bus.data_out), 32'(m_out));
        check_output({tag, " data_valid"}, 32'(bus.data_valid), 32'(m_valid));
        check_output({tag, " overrun"}, 32'(overrun), 32'(m_ovr));
    endtask

    task automatic send_word(input logic [7:0] w, input logic rdy, input string tag);
        for (int k = WIDTH - 1; k >= 0; k--) begin
            apply_stimulus(w[k], 5 + int'($urandom_range(0, 4)), 0, rdy);
            check_output({tag, " bit_cnt"}, 32'(bit_cnt), 32'(m_cnt));
        end
        check_state(tag);
        if (m_done && rdy) begin
            check_output({tag, " valid pulse"}, 32'(pulse_cycles), 32'd1);
            check_output({tag, " latency"}, 32'(latency), 32'(SAMPLE_DLY + 2));
        end
    endtask

    logic [7:0] rnd_word;
    logic       rnd_rdy;

    initial begin
        bus.SSER       = 1'b1;
        bus.BA13       = 1'b0;
        bus.BA12       = 1'b0;
        bus.BR_W       = 1'b0;
        bus.SDRD       = 1'b0;
        bus.data_ready = 1'b0;
        model_reset();

        // Reset values
        repeat (3) @(negedge clk);
        check_state("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_state("after release");

        // 0xB2 with a ready consumer
        send_word(8'hB2, 1'b1, "word_b2");
        check_output("word_b2 out const", 32'(bus.data_out), 32'h0000_00B2);

        // Two words with no consumer: second one is dropped
        send_word(8'hB2, 1'b0, "hold_b2");
        send_word(8'h5A, 1'b0, "drop_5a");
        check_output("drop_5a out const", 32'(bus.data_out), 32'h0000_00B2);
        @(negedge clk);
        bus.data_ready = 1'b1;
        @(negedge clk);
        bus.data_ready = 1'b0;
        m_valid = 1'b0;
        check_state("consume one clock");

        // Long access samples once
        apply_stimulus(1'b1, 10, 0, 1'b1);
        check_output("long access bit_cnt", 32'(bit_cnt), 32'd1);
        for (int k = 0; k < WIDTH - 1; k++) apply_stimulus(1'($urandom_range(0, 1)), 6, 0, 1'b1);
        check_state("long access word");

        // Windows that do not decode to a read
        for (int kind = 1; kind <= 3; kind++) begin
            apply_stimulus(1'b1, 10, kind, 1'b1);
            check_output($sformatf("bad window %0d bit_cnt", kind), 32'(bit_cnt), 32'd0);
        end

        // Idle timeout discards a partial word
        for (int k = 0; k < 3; k++) apply_stimulus(1'($urandom_range(0, 1)), 6, 0, 1'b1);
        check_output("timeout partial", 32'(bit_cnt), 32'd3);
        repeat (100) @(negedge clk);
        check_output("timeout not yet", 32'(bit_cnt), 32'd3);
        repeat (160) @(negedge clk);
        m_cnt  = 0;
        m_word = '0;
        check_output("timeout expired", 32'(bit_cnt), 32'd0);
        send_word(8'hFF, 1'b1, "after timeout");

        // resync drops the partial word only
        for (int k = 0; k < 4; k++) apply_stimulus(1'($urandom_range(0, 1)), 6, 0, 1'b0);
        check_output("pre resync", 32'(bit_cnt), 32'd4);
        @(negedge clk);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        m_cnt  = 0;
        m_word = '0;
        check_state("resync");

        // Random words with random consumer behaviour
        for (int w = 0; w < 4; w++) begin
            rnd_word = 8'($urandom_range(0, 255));
            rnd_rdy  = (w == 3) ? 1'b0 : 1'($urandom_range(0, 1));
            send_word(rnd_word, rnd_rdy, $sformatf("random %0d", w));
        end

        // Reset asserted while the sixth bit is being sampled
        for (int k = 0; k < 5; k++) apply_stimulus(1'($urandom_range(0, 1)), 6, 0, 1'b0);
        check_output("pre reset partial", 32'(bit_cnt), 32'd5);
        @(negedge clk);
        bus.SSER = 1'b0;
        bus.BA13 = 1'b0;
        bus.BA12 = 1'b1;
        bus.BR_W = 1'b1;
        bus.SDRD = 1'b1;
        repeat (SAMPLE_DLY + 2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_state("reset in sample");
        @(negedge clk);
        close_window();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_state("reset released");
        send_word(8'h3C, 1'b0, "word_3c");
        check_output("word_3c out const", 32'(bus.data_out), 32'h0000_003C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
